// File: rtl/timing_adapter_fifo_param_if.sv
// Ready/valid stream bundle between an upstream producer, the FIFO and a downstream consumer.
// Handshake: a word moves on a rising edge exactly when valid and ready are both high; valid
// never waits on ready, and a producer seeing valid && !ready must hold its word unchanged.
interface timing_adapter_fifo_param_if #(
  parameter int DATA_WIDTH = 37
) ();
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/timing_adapter_fifo_param.sv
// Parametrised show-ahead ready/valid FIFO with synchronous flush, almost-full/empty flags
// and a high-water-mark monitor. Pointers carry one extra wrap bit to tell full from empty.
module timing_adapter_fifo_param #(
  parameter int DATA_WIDTH      = 37,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  timing_adapter_fifo_param_if.slave bus,
  output logic [ADDR_WIDTH:0]        fill_level,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [ADDR_WIDTH:0]        high_water
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [31:0] AF_TH = ALMOST_FULL_TH;
  localparam logic [31:0] AE_TH = ALMOST_EMPTY_TH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   high_water_q, high_water_d;
  logic [ADDR_WIDTH:0]   fill_next;
  logic [31:0]           fill_wide;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  always_comb begin
    fill_level = wr_ptr_q - rd_ptr_q;
    fill_wide  = {{(31 - ADDR_WIDTH){1'b0}}, fill_level};
    full       = (fill_level == DEPTH_W);
    empty      = (fill_level == '0);

    // Full blocks a write even when a read happens on the same edge: no pass-through.
    bus.in_ready  = !full && !flush;
    bus.out_valid = !empty;
    bus.out_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];

    do_wr = bus.in_valid && bus.in_ready;
    do_rd = bus.out_valid && bus.out_ready && !flush;

    almost_full  = (fill_wide >= AF_TH);
    almost_empty = (fill_wide <= AE_TH);
    high_water   = high_water_q;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, do_wr};
    rd_ptr_d     = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, do_rd};
    high_water_d = high_water_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    fill_next = wr_ptr_d - rd_ptr_d;
    if (flush) begin
      high_water_d = '0;
    end else if (fill_next > high_water_q) begin
      high_water_d = fill_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      high_water_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      high_water_q <= high_water_d;
    end
  end

  // Storage is deliberately not reset or flushed; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_timing_adapter_fifo_param.sv
// Bench for timing_adapter_fifo_param: directed vector table, hand-written corner sequences
// and a randomized phase checked against a queue-based model of the FIFO.
module tb_timing_adapter_fifo_param;
  localparam int DW    = 37;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [AW:0]   fill_level;
  logic [AW:0]   high_water;
  logic          almost_full;
  logic          almost_empty;

  timing_adapter_fifo_param_if #(.DATA_WIDTH(DW)) bus ();

  timing_adapter_fifo_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ALMOST_FULL_TH(AF_TH),
    .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus.slave),
    .fill_level(fill_level),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .high_water(high_water)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q [$];
  int model_hw = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] data;
    logic          ordy;
    int            fill;
    logic          valid;
    logic [DW-1:0] odata;
    logic          irdy;
    logic          af;
    logic          ae;
    int            hw;
  } vec_t;

  vec_t vecs [29];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // Advance one edge and apply the FIFO rules to the model with the inputs seen at that edge.
  task automatic edge_update();
    int pre;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      model_hw = 0;
    end else begin
      pre = exp_q.size();
      if (bus.out_ready && pre > 0) void'(exp_q.pop_front());
      if (bus.in_valid && pre < DEPTH) exp_q.push_back(bus.in_data);
      if (exp_q.size() > model_hw) model_hw = exp_q.size();
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, ":out_valid"}, 64'(bus.out_valid), 64'(sz > 0));
    if (sz > 0) chk({tag, ":out_data"}, 64'(bus.out_data), 64'(exp_q[0]));
    chk({tag, ":fill_level"}, 64'(fill_level), 64'(sz));
    chk({tag, ":in_ready"}, 64'(bus.in_ready), 64'((sz < DEPTH) && !flush));
    chk({tag, ":almost_full"}, 64'(almost_full), 64'(sz >= AF_TH));
    chk({tag, ":almost_empty"}, 64'(almost_empty), 64'(sz <= AE_TH));
    chk({tag, ":high_water"}, 64'(high_water), 64'(model_hw));
  endtask

  task automatic model_cycle(input string tag, input logic iv, input logic [DW-1:0] d,
                             input logic ordy, input logic fl);
    set_in(iv, d, ordy, fl);
    @(negedge clk);
    check_model(tag);
    edge_update();
  endtask

  // ---------------- test ----------------
  initial begin
    logic [DW-1:0] rd;
    int r;

    // Directed table: idle, fill to full, hold a blocked word, drain in order.
    for (int i = 0; i < 10; i++)
      vecs[i] = '{iv: 1'b0, data: '0, ordy: 1'b0, fill: 0, valid: 1'b0, odata: '0,
                  irdy: 1'b1, af: 1'b0, ae: 1'b1, hw: 0};
    for (int i = 0; i < 8; i++)
      vecs[10 + i] = '{iv: 1'b1, data: DW'(i + 1), ordy: 1'b0, fill: i, valid: (i > 0),
                       odata: DW'(1), irdy: 1'b1, af: (i >= 6), ae: (i <= 1), hw: i};
    for (int i = 0; i < 2; i++)
      vecs[18 + i] = '{iv: 1'b1, data: DW'(32'h1F), ordy: 1'b0, fill: 8, valid: 1'b1,
                       odata: DW'(1), irdy: 1'b0, af: 1'b1, ae: 1'b0, hw: 8};
    for (int k = 0; k < 8; k++)
      vecs[20 + k] = '{iv: 1'b0, data: '0, ordy: 1'b1, fill: 8 - k, valid: 1'b1,
                       odata: DW'(k + 1), irdy: (k > 0), af: ((8 - k) >= 6),
                       ae: ((8 - k) <= 1), hw: 8};
    vecs[28] = '{iv: 1'b0, data: '0, ordy: 1'b1, fill: 0, valid: 1'b0, odata: '0,
                 irdy: 1'b1, af: 1'b0, ae: 1'b1, hw: 8};

    reset = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      set_in(vecs[i].iv, vecs[i].data, vecs[i].ordy, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d:fill_level", i), 64'(fill_level), 64'(vecs[i].fill));
      chk($sformatf("vec%0d:out_valid", i), 64'(bus.out_valid), 64'(vecs[i].valid));
      if (vecs[i].valid)
        chk($sformatf("vec%0d:out_data", i), 64'(bus.out_data), 64'(vecs[i].odata));
      chk($sformatf("vec%0d:in_ready", i), 64'(bus.in_ready), 64'(vecs[i].irdy));
      chk($sformatf("vec%0d:almost_full", i), 64'(almost_full), 64'(vecs[i].af));
      chk($sformatf("vec%0d:almost_empty", i), 64'(almost_empty), 64'(vecs[i].ae));
      chk($sformatf("vec%0d:high_water", i), 64'(high_water), 64'(vecs[i].hw));
      edge_update();
    end

    // Streaming through the wrap: output equals input delayed by one cycle.
    for (int c = 0; c < 40; c++) begin
      set_in(1'b1, DW'(100 + c), 1'b1, 1'b0);
      @(negedge clk);
      check_model("stream");
      chk("stream:fill_le1", 64'(fill_level <= 1), 64'd1);
      if (c > 0) chk("stream:delayed", 64'(bus.out_data), 64'(100 + c - 1));
      edge_update();
    end
    model_cycle("stream_tail", 1'b0, '0, 1'b1, 1'b0);

    // Flush mid-stream at fill_level 5.
    for (int i = 0; i < 5; i++) model_cycle("pre_flush", 1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
    set_in(1'b1, DW'(32'h55), 1'b1, 1'b1);
    @(negedge clk);
    chk("flush:fill_before", 64'(fill_level), 64'd5);
    chk("flush:in_ready", 64'(bus.in_ready), 64'd0);
    edge_update();
    set_in(1'b1, DW'(32'hABC), 1'b0, 1'b0);
    @(negedge clk);
    chk("flush:fill_after", 64'(fill_level), 64'd0);
    chk("flush:out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush:high_water", 64'(high_water), 64'd0);
    edge_update();
    set_in(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush:first_valid", 64'(bus.out_valid), 64'd1);
    chk("flush:first_word", 64'(bus.out_data), 64'(32'hABC));
    edge_update();

    // Async reset in the middle of a simultaneous read/write at fill_level 4.
    for (int i = 0; i < 4; i++) model_cycle("pre_reset", 1'b1, DW'(32'h300 + i), 1'b0, 1'b0);
    set_in(1'b1, DW'(32'h3FF), 1'b1, 1'b0);
    @(negedge clk);
    check_model("pre_reset_rw");
    #1 reset = 1'b1;
    #1;
    chk("areset:fill_level", 64'(fill_level), 64'd0);
    chk("areset:out_valid", 64'(bus.out_valid), 64'd0);
    chk("areset:in_ready", 64'(bus.in_ready), 64'd1);
    chk("areset:almost_full", 64'(almost_full), 64'd0);
    chk("areset:almost_empty", 64'(almost_empty), 64'd1);
    chk("areset:high_water", 64'(high_water), 64'd0);
    exp_q.delete();
    model_hw = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) model_cycle("post_reset", 1'b1, DW'(32'h400 + i), (i > 2), 1'b0);

    // Randomized traffic with occasional flush.
    for (int c = 0; c < 400; c++) begin
      rd[31:0]  = $urandom();
      rd[36:32] = 5'($urandom_range(0, 31));
      r = $urandom_range(0, 99);
      model_cycle("rand", ($urandom_range(0, 9) < 6), rd, ($urandom_range(0, 1) == 1), (r < 3));
    end
    for (int c = 0; c < DEPTH + 1; c++) model_cycle("drain", 1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
